// File: rtl/memblock_tbus_arb_pkg.sv
// Shared constants and types for the trinity-bus arbiter between the load unit,
// the store-commit unit and dcache.
package memblock_tbus_arb_pkg;

    localparam int RESULT_WIDTH  = 64;
    localparam int TBUS_OPTYPE_W = 2;

    localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'b00;
    localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    typedef enum logic {
        LDU = 1'b0,
        STU = 1'b1
    } owner_t;

endpackage

// File: rtl/memblock_tbus_arb_if.sv
// One trinity-bus port: a request channel (valid/ready + payload) and a response
// channel (read_data qualified by the single-cycle operation_done strobe).
//
// Handshake: a request transfers on a rising clock edge where valid && ready.
// ready may depend combinationally on valid. Once the arbiter raises valid on the
// dcache side it holds valid and payload stable until that transfer.
// operation_done is a one-cycle strobe with no back-pressure; read_data is only
// meaningful while operation_done is high.
interface memblock_tbus_arb_if
    import memblock_tbus_arb_pkg::*;
#(
    parameter int ADDR_W   = RESULT_WIDTH,
    parameter int DATA_W   = 64,
    parameter int MASK_W   = 64,
    parameter int OPTYPE_W = TBUS_OPTYPE_W
) ();

    logic                valid;
    logic                ready;
    logic [ADDR_W-1:0]   index;
    logic [DATA_W-1:0]   write_data;
    logic [MASK_W-1:0]   write_mask;
    logic [OPTYPE_W-1:0] operation_type;
    logic [DATA_W-1:0]   read_data;
    logic                operation_done;

    modport master (
        output valid, index, write_data, write_mask, operation_type,
        input  ready, read_data, operation_done
    );

    modport slave (
        input  valid, index, write_data, write_mask, operation_type,
        output ready, read_data, operation_done
    );

endinterface

// File: rtl/memblock_tbus_arb_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, ties go to the input that did
// not win last time. Bit 0 / last_grant=0 is the load side.
module memblock_tbus_arb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (&req) grant = last_grant ? 2'b01 : 2'b10;
            else      grant = req;
        end
    end

endmodule

// File: rtl/memblock_tbus_arb.sv
// Arbitrates ldu and stu trinity-bus requests onto the single dcache port, keeps
// one operation in flight and routes its response back to the owner.
module memblock_tbus_arb
    import memblock_tbus_arb_pkg::*;
#(
    parameter int ADDR_W   = RESULT_WIDTH,
    parameter int DATA_W   = 64,
    parameter int MASK_W   = 64,
    parameter int OPTYPE_W = TBUS_OPTYPE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ldu_flush,
    memblock_tbus_arb_if.slave  ldu,
    memblock_tbus_arb_if.slave  stu,
    memblock_tbus_arb_if.master dc,
    output state_t              state
);

    state_t              state_q, state_d;
    owner_t              owner_q, last_q, grant_src;
    logic                drop_q;
    logic                aborted_q;
    logic [ADDR_W-1:0]   index_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [OPTYPE_W-1:0] optype_q;

    logic [1:0] grant;
    logic       fire;
    logic       owner_done;
    logic       ldu_done;
    logic       stu_done;

    // A flushing load is not eligible; the store may still win that cycle.
    memblock_tbus_arb_rr_arb2 u_rr_arb2 (
        .req        ({stu.valid, ldu.valid & ~ldu_flush}),
        .last_grant (last_q == STU),
        .en         ((state_q == IDLE) && !reset),
        .grant      (grant)
    );

    assign fire      = |grant;
    assign grant_src = grant[1] ? STU : LDU;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire)              state_d = ISSUE;
            ISSUE:   if (dc.ready)          state_d = WAIT;
            WAIT:    if (dc.operation_done) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= LDU;
            last_q    <= STU;
            drop_q    <= 1'b0;
            // Remember that a response may still arrive for the aborted operation.
            aborted_q <= aborted_q | (state_q != IDLE);
            index_q   <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            optype_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                owner_q   <= grant_src;
                last_q    <= grant_src;
                drop_q    <= 1'b0;
                aborted_q <= 1'b0;
                index_q   <= grant[1] ? stu.index          : ldu.index;
                wdata_q   <= grant[1] ? stu.write_data     : ldu.write_data;
                wmask_q   <= grant[1] ? stu.write_mask     : ldu.write_mask;
                optype_q  <= grant[1] ? stu.operation_type : ldu.operation_type;
            end else if ((state_q != IDLE) && (owner_q == LDU) && ldu_flush) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign ldu.ready = grant[0];
    assign stu.ready = grant[1];

    assign dc.valid          = (state_q == ISSUE);
    assign dc.index          = dc.valid ? index_q  : '0;
    assign dc.write_data     = dc.valid ? wdata_q  : '0;
    assign dc.write_mask     = dc.valid ? wmask_q  : '0;
    assign dc.operation_type = dc.valid ? optype_q : '0;

    // A flush arriving together with the done swallows that done as well.
    assign owner_done = dc.operation_done && (state_q == WAIT) && !reset;
    assign ldu_done   = owner_done && (owner_q == LDU) && !drop_q && !ldu_flush;
    assign stu_done   = owner_done && (owner_q == STU);

    assign ldu.operation_done = ldu_done;
    assign ldu.read_data      = ldu_done ? dc.read_data : '0;
    assign stu.operation_done = stu_done;
    assign stu.read_data      = stu_done ? dc.read_data : '0;

    assign state = state_q;

    a_done_with_accept: assert property (@(posedge clock) disable iff (reset)
        !(dc.valid && dc.ready && dc.operation_done));

    a_done_outside_wait: assert property (@(posedge clock) disable iff (reset)
        dc.operation_done |-> ((state_q == WAIT) || aborted_q));

endmodule
